// File: rtl/afg_seq_pkg.sv
// Shared types and constants for the waveform playback sequencer.
package afg_seq_pkg;

  // Default datapath widths
  localparam int DEF_ADDR_W  = 14;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_DIV_W   = 16;

  // Supported RAM read latency range (address to data, in clocks)
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int DEF_MEM_LAT = 2;

  // Playback sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate prescaler: emits one tick every div_i+1 enabled clocks,
// starting with a tick on the first enabled clock after a clear.
module sample_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count 0..div_i while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q >= div_i) ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Prescaler count register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/waveform_playback_sequencer.sv
// Plays one waveform segment out of RAM when the trigger level rises:
// issues read strobes at a programmable rate, repeats the segment
// Cycle_Count times (0 = forever), waits for the read pipe to empty and
// returns a one-clock Ending_Sout pulse.
//
// Read interface: Mem_Rd_EN high for one clock qualifies Wave_Addr in that
// same clock; the RAM has no backpressure. Sample_Valid is high exactly
// MEM_LAT clocks after each strobe, marking the matching read data.
module waveform_playback_sequencer
  import afg_seq_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              Clock,
  input  logic              Reset_N,
  input  logic              Trig_Ctrl_Sin,
  input  logic [ADDR_W-1:0] Start_Addr,
  input  logic [ADDR_W-1:0] Stop_Addr,
  input  logic [CNT_W-1:0]  Cycle_Count,
  input  logic [DIV_W-1:0]  Sample_Div,
  output logic [ADDR_W-1:0] Wave_Addr,
  output logic              Mem_Rd_EN,
  output logic              Sample_Valid,
  output logic              Busy,
  output logic              Ending_Sout,
  output seq_state_e        Seq_State
);

  seq_state_e        state_q;
  logic              trig_prev_q;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] stop_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [DIV_W-1:0]  div_q;
  logic [CNT_W-1:0]  rem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [MEM_LAT-1:0] pipe_q;
  logic [MEM_LAT-1:0] pipe_d;

  logic rise;
  logic tick;
  logic in_play;
  logic running;
  logic abort;
  logic pipe_empty;
  logic at_stop;
  logic last_lap;

  assign rise       = Trig_Ctrl_Sin && !trig_prev_q;
  assign in_play    = (state_q == PLAY);
  assign running    = (state_q == PLAY) || (state_q == DRAIN);
  assign abort      = running && !Trig_Ctrl_Sin;
  assign pipe_empty = (pipe_q == '0);
  assign at_stop    = (addr_q == stop_q);
  assign last_lap   = (cyc_q != '0) && (rem_q == CNT_W'(1));

  // Prescaler is held cleared outside PLAY so the first PLAY cycle ticks
  sample_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk_i   (Clock),
    .rst_n_i (Reset_N),
    .clear_i (!in_play),
    .en_i    (in_play),
    .div_i   (div_q),
    .tick_o  (tick)
  );

  // Playback FSM with config snapshot, address walk and repeat counting
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= IDLE;
      trig_prev_q <= 1'b0;
      start_q     <= '0;
      stop_q      <= '0;
      cyc_q       <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
    end else begin
      trig_prev_q <= Trig_Ctrl_Sin;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            start_q <= Start_Addr;
            stop_q  <= Stop_Addr;
            cyc_q   <= Cycle_Count;
            div_q   <= Sample_Div;
            rem_q   <= Cycle_Count;
            addr_q  <= Start_Addr;
            state_q <= PLAY;
          end
        end
        PLAY: begin
          if (!Trig_Ctrl_Sin) begin
            state_q <= IDLE;
          end else if (tick) begin
            if (!at_stop) begin
              addr_q <= addr_q + ADDR_W'(1);
            end else if (last_lap) begin
              state_q <= DRAIN;
            end else begin
              addr_q <= start_q;
              if (cyc_q != '0) begin
                rem_q <= rem_q - CNT_W'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (!Trig_Ctrl_Sin) begin
            state_q <= IDLE;
          end else if (pipe_empty) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!Trig_Ctrl_Sin) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  // Valid pipe: strobe history shifted MEM_LAT deep, flushed on abort
  always_comb begin
    pipe_d = '0;
    if (!abort) begin
      pipe_d[0] = Mem_Rd_EN;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  // Valid pipe register
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign Wave_Addr    = addr_q;
  assign Mem_Rd_EN    = tick;
  assign Sample_Valid = pipe_q[MEM_LAT-1];
  assign Busy         = running;
  assign Ending_Sout  = (state_q == DRAIN) && pipe_empty && Trig_Ctrl_Sin;
  assign Seq_State    = state_q;

endmodule

// File: tb/tb_waveform_playback_sequencer.sv
// Bench for waveform_playback_sequencer: directed playbacks checked against
// a schedule-based model every clock, plus literal spot checks.
module tb_waveform_playback_sequencer;
  import afg_seq_pkg::*;

  localparam int AW = 14;
  localparam int CW = 16;
  localparam int DW = 16;
  localparam int ML = 2;
  localparam longint AMOD = 64'd1 << AW;

  // ---------------- clock / reset ----------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          trig  = 1'b0;
  logic [AW-1:0] start_a = '0;
  logic [AW-1:0] stop_a  = '0;
  logic [CW-1:0] cyc_cnt = '0;
  logic [DW-1:0] div_v   = '0;

  logic [AW-1:0] wave_addr;
  logic          mem_rd, samp_valid, busy, ending;
  seq_state_e    seq_state;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  waveform_playback_sequencer #(
    .ADDR_W (AW), .CNT_W (CW), .DIV_W (DW), .MEM_LAT (ML)
  ) dut (
    .Clock         (clk),
    .Reset_N       (rst_n),
    .Trig_Ctrl_Sin (trig),
    .Start_Addr    (start_a),
    .Stop_Addr     (stop_a),
    .Cycle_Count   (cyc_cnt),
    .Sample_Div    (div_v),
    .Wave_Addr     (wave_addr),
    .Mem_Rd_EN     (mem_rd),
    .Sample_Valid  (samp_valid),
    .Busy          (busy),
    .Ending_Sout   (ending),
    .Seq_State     (seq_state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  int     m_mode = M_IDLE;
  bit     m_prev = 1'b0;
  longint m_t, m_start, m_len, m_n, m_per;
  bit     m_cont;
  logic [AW-1:0] exp_q[$];

  function automatic bit strobe_at(longint t);
    if (t < 0) return 1'b0;
    if ((t % m_per) != 0) return 1'b0;
    if (!m_cont && (t / m_per) >= m_n) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin : compare
    bit e_rd, e_sv, e_end, e_busy;
    int e_state;
    longint last_t, end_t;
    logic [AW-1:0] ea, got_a;
    if (!rst_n) begin
      chk("rst_rd", mem_rd, 0);
      chk("rst_valid", samp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_end", ending, 0);
      m_mode = M_IDLE;
      m_prev = 1'b0;
      exp_q.delete();
    end else begin
      e_rd = 0; e_sv = 0; e_end = 0; e_busy = 0; e_state = int'(IDLE);
      ea = '0; last_t = 0; end_t = 0;
      if (m_mode == M_RUN) begin
        last_t  = (m_n - 1) * m_per;
        end_t   = last_t + ML + 1;
        e_rd    = strobe_at(m_t);
        ea      = AW'((m_start + ((m_t / m_per) % m_len)) % AMOD);
        e_sv    = strobe_at(m_t - ML);
        e_end   = !m_cont && (m_t == end_t) && trig;
        e_busy  = 1'b1;
        e_state = (!m_cont && m_t > last_t) ? int'(DRAIN) : int'(PLAY);
      end else if (m_mode == M_DONE) begin
        e_state = int'(DONE);
      end
      if (e_rd) exp_q.push_back(ea);
      if (mem_rd === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb_addr: unexpected read strobe at addr %0d t=%0t", wave_addr, $time);
        end else begin
          got_a = exp_q.pop_front();
          chk("sb_addr", wave_addr, got_a);
        end
      end
      chk("m_rd", mem_rd, e_rd);
      chk("m_valid", samp_valid, e_sv);
      chk("m_end", ending, e_end);
      chk("m_busy", busy, e_busy);
      chk("m_state", seq_state, e_state);
      // advance the model to the next cycle using this cycle's inputs
      case (m_mode)
        M_IDLE: if (trig && !m_prev) begin
          m_start = longint'(start_a);
          m_len   = ((longint'(stop_a) - longint'(start_a)) % AMOD + AMOD) % AMOD + 1;
          m_cont  = (cyc_cnt == 0);
          m_n     = m_len * longint'(cyc_cnt);
          m_per   = longint'(div_v) + 1;
          m_t     = 0;
          m_mode  = M_RUN;
        end
        M_RUN: begin
          if (!trig) m_mode = M_IDLE;
          else if (!m_cont && m_t == end_t) m_mode = M_DONE;
          else m_t++;
        end
        default: if (!trig) m_mode = M_IDLE;
      endcase
      m_prev = trig;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic cfg(input int s, input int p, input int c, input int d);
    start_a = AW'(s);
    stop_a  = AW'(p);
    cyc_cnt = CW'(c);
    div_v   = DW'(d);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int n, m, r;
    #1 rst_n = 1'b0;
    cfg(0, 0, 1, 0);
    step(3);
    @(negedge clk);
    chk("reset_addr", wave_addr, 0);
    chk("reset_state", seq_state, IDLE);
    @(posedge clk); #1 rst_n = 1'b1;
    step(3);

    // Two laps of 10..13 at full rate
    cfg(10, 13, 2, 0); trig = 1'b1; n = cyc;
    wait_neg(n + 1);  chk("t1_rd_first", mem_rd, 1); chk("t1_addr_first", wave_addr, 10);
    wait_neg(n + 3);  chk("t1_valid_first", samp_valid, 1);
    wait_neg(n + 4);  chk("t1_addr_stop", wave_addr, 13);
    wait_neg(n + 5);  chk("t1_addr_lap2", wave_addr, 10);
    wait_neg(n + 8);  chk("t1_rd_last", mem_rd, 1); chk("t1_addr_last", wave_addr, 13);
    wait_neg(n + 9);  chk("t1_rd_off", mem_rd, 0);
    wait_neg(n + 10); chk("t1_valid_last", samp_valid, 1); chk("t1_end_early", ending, 0);
    wait_neg(n + 11); chk("t1_end", ending, 1); chk("t1_busy_end", busy, 1); chk("t1_valid_off", samp_valid, 0);
    wait_neg(n + 12); chk("t1_busy_off", busy, 0); chk("t1_done", seq_state, DONE);
    wait_neg(n + 20); chk("t1_no_restart", seq_state, DONE); chk("t1_no_rd", mem_rd, 0);

    // One-clock low then rise: fresh config with Div=2
    @(posedge clk); #1 trig = 1'b0; cfg(10, 13, 2, 2);
    @(posedge clk); #1 trig = 1'b1; n = cyc;
    wait_neg(n + 1);  chk("t2_rd_first", mem_rd, 1); chk("t2_addr_first", wave_addr, 10);
    wait_neg(n + 2);  chk("t2_rd_gap", mem_rd, 0);
    wait_neg(n + 4);  chk("t2_rd_second", mem_rd, 1); chk("t2_addr_second", wave_addr, 11);
    wait_neg(n + 22); chk("t2_rd_last", mem_rd, 1); chk("t2_addr_last", wave_addr, 13);
    wait_neg(n + 24); chk("t2_end_early", ending, 0);
    wait_neg(n + 25); chk("t2_end", ending, 1);
    wait_neg(n + 26); chk("t2_busy_off", busy, 0);
    @(posedge clk); #1 trig = 1'b0;
    step(2);

    // Segment wrapping across the top of RAM
    cfg(16382, 1, 1, 0); trig = 1'b1; n = cyc;
    wait_neg(n + 1); chk("t3_addr0", wave_addr, 16382);
    wait_neg(n + 2); chk("t3_addr1", wave_addr, 16383);
    wait_neg(n + 3); chk("t3_addr2", wave_addr, 0);
    wait_neg(n + 4); chk("t3_addr3", wave_addr, 1); chk("t3_rd3", mem_rd, 1);
    wait_neg(n + 5); chk("t3_rd_off", mem_rd, 0);
    wait_neg(n + 7); chk("t3_end", ending, 1);
    @(posedge clk); #1 trig = 1'b0;
    step(2);

    // Continuous one-sample segment, inputs changed mid-play, then abort
    cfg(5, 5, 0, 0); trig = 1'b1; n = cyc;
    step(3);
    cfg(7, 9, 1, 3);
    wait_neg(n + 1000); chk("t4_addr", wave_addr, 5); chk("t4_rd", mem_rd, 1);
    @(posedge clk); #1 trig = 1'b0; m = cyc;
    wait_neg(m + 1);
    chk("t4_abort_rd", mem_rd, 0);
    chk("t4_abort_valid", samp_valid, 0);
    chk("t4_abort_state", seq_state, IDLE);
    chk("t4_abort_end", ending, 0);
    step(2);

    // Asynchronous reset mid-play, trigger held high through release
    cfg(100, 103, 3, 1); trig = 1'b1; n = cyc;
    wait_neg(n + 6);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_rd", mem_rd, 0);
    chk("t5_rst_valid", samp_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr", wave_addr, 0);
    chk("t5_rst_state", seq_state, IDLE);
    step(2);
    @(posedge clk); #3 rst_n = 1'b1; r = cyc;
    wait_neg(r + 1);  chk("t5_rd_first", mem_rd, 1); chk("t5_addr_first", wave_addr, 100);
    wait_neg(r + 26); chk("t5_end", ending, 1);
    @(posedge clk); #1 trig = 1'b0;
    step(3);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
